// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes ch_a/ch_b, decodes Gray-code steps
// into a step pulse, a direction flag and an 8-bit wrapping position,
// and flags illegal double-bit transitions with a sticky err.
// Optional input glitch filter: define QDEC_FILTER_EN to enable it.
module quad_decoder (
   input  logic       clk,
   input  logic       clr,
   input  logic       ch_a,
   input  logic       ch_b,
   input  logic       en,
   output logic       step,
   output logic       up,
   output logic [7:0] pos,
   output logic       err
);

`ifdef QDEC_FILTER_EN
   // Sync stages plus two history stages must hold real samples before priming.
   localparam int FILL = 4;
`else
   localparam int FILL = 2;
`endif

   logic [1:0]      sync_p0;
   logic [1:0]      sync_p1;
   logic [FILL-1:0] fill;
   logic            primed;
   logic [1:0]      prev;
   logic [1:0]      cur;
   logic            is_up;
   logic            is_dn;
   logic            illegal;

   // Two-flop synchronizer for the channel pair, plus a fill marker that
   // tracks how far genuine post-reset samples have travelled.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_p0 <= 2'b00;
         sync_p1 <= 2'b00;
         fill    <= '0;
      end else begin
         sync_p0 <= {ch_a, ch_b};
         sync_p1 <= sync_p0;
         fill    <= {fill[FILL-2:0], 1'b1};
      end
   end

`ifdef QDEC_FILTER_EN
   logic [1:0] hist_p2;
   logic [1:0] hist_p3;
   logic [1:0] filt;

   // Per-channel history and last accepted (filtered) value.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hist_p2 <= 2'b00;
         hist_p3 <= 2'b00;
         filt    <= 2'b00;
      end else begin
         hist_p2 <= sync_p1;
         hist_p3 <= hist_p2;
         filt    <= cur;
      end
   end

   // A channel takes a new value only when its last three samples agree.
   always_comb begin
      cur = filt;
      for (int i = 0; i < 2; i++) begin
         if ((sync_p1[i] == hist_p2[i]) && (hist_p2[i] == hist_p3[i]))
            cur[i] = sync_p1[i];
      end
   end
`else
   assign cur = sync_p1;
`endif

   // Classify the transition from prev to the current sample.
   always_comb begin
      is_up   = 1'b0;
      is_dn   = 1'b0;
      illegal = ((prev ^ cur) == 2'b11);
      case ({prev, cur})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_dn = 1'b1;
         default: ;
      endcase
   end

   // Priming, registered step/direction, position counting and sticky error.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         prev   <= 2'b00;
         primed <= 1'b0;
         step   <= 1'b0;
         up     <= 1'b0;
         pos    <= 8'h00;
         err    <= 1'b0;
      end else begin
         step <= 1'b0;
         if (fill[FILL-1]) begin
            prev   <= cur;
            primed <= 1'b1;
            if (primed) begin
               if (is_up || is_dn) begin
                  step <= 1'b1;
                  up   <= is_up;
                  if (en)
                     pos <= is_up ? pos + 8'd1 : pos - 8'd1;
               end
               if (illegal)
                  err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: vector table, hand-written corner sequences and
// randomized phase walks checked against a phase-arithmetic model.
module tb_quad_decoder;

`ifdef QDEC_FILTER_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       ch_a;
   logic       ch_b;
   logic       en;
   logic       step;
   logic       up;
   logic [7:0] pos;
   logic       err;

   quad_decoder dut (
      .clk  (clk),
      .clr  (clr),
      .ch_a (ch_a),
      .ch_b (ch_b),
      .en   (en),
      .step (step),
      .up   (up),
      .pos  (pos),
      .err  (err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // Model: quadrature phase 0..3 around the cycle 00,01,11,10.
   int         m_ph;
   logic [7:0] m_pos;
   logic       m_up;
   logic       m_err;
   int         phmap [4] = '{0, 1, 3, 2};      // index {a,b}
   logic [1:0] phinv [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   typedef struct {
      logic       a;
      logic       b;
      logic       e;
      int         steps;
      logic       up;
      logic [7:0] pos;
      logic       err;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic model_step(input logic a, input logic b, input logic e, output int nsteps);
      int np;
      int d;
      np = phmap[{a, b}];
      d  = (np - m_ph) & 3;
      m_ph = np;
      nsteps = 0;
      if (d == 1) begin
         m_up = 1'b1;
         if (e) m_pos = m_pos + 8'd1;
         nsteps = 1;
      end else if (d == 3) begin
         m_up = 1'b0;
         if (e) m_pos = m_pos - 8'd1;
         nsteps = 1;
      end else if (d == 2) begin
         m_err = 1'b1;
      end
   endtask

   // Apply inputs right after a falling edge, hold, count step pulses and
   // check when the single expected pulse appeared.
   task automatic drive(input logic a, input logic b, input logic e, input int hold,
                        input int exp_steps, input string name);
      int cnt;
      int first;
      ch_a = a; ch_b = b; en = e;
      cnt = 0; first = -1;
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         if (step) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      check({name, " steps"}, cnt, exp_steps);
      if (exp_steps == 1) check({name, " latency"}, first, LAT + 1);
   endtask

   task automatic apply_model(input logic a, input logic b, input logic e, input int hold,
                              input string name);
      int ns;
      model_step(a, b, e, ns);
      drive(a, b, e, hold, ns, name);
      check({name, " up"},  int'(up),  int'(m_up));
      check({name, " pos"}, int'(pos), int'(m_pos));
      check({name, " err"}, int'(err), int'(m_err));
   endtask

   initial begin
      int ns;
      int r;
      int d;
      logic [1:0] pr;

      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 8'h01, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 8'h02, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h03, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h04, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h04, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h04, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h04, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h05, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 8'h04, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h03, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 8'h02, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 8'h01, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 8'hFF, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h00, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h01, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 8'h01, 1'b0};
      tbl[17] = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 8'h01, 1'b1};

      // Reset with inputs idle.
      clr = 1'b1; ch_a = 1'b0; ch_b = 1'b0; en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset step", int'(step), 0);
      check("reset up",   int'(up),   0);
      check("reset pos",  int'(pos),  0);
      check("reset err",  int'(err),  0);
      clr = 1'b0;
      repeat (10) @(negedge clk);
      m_ph = 0; m_pos = 8'h00; m_up = 1'b0; m_err = 1'b0;

      // Table: up run, en=0 run, down run through wrap, idle, illegal jump.
      for (int i = 0; i < 18; i++) begin
         model_step(tbl[i].a, tbl[i].b, tbl[i].e, ns);
         drive(tbl[i].a, tbl[i].b, tbl[i].e, 8, tbl[i].steps, $sformatf("vec%0d", i));
         check($sformatf("vec%0d up", i),  int'(up),  int'(tbl[i].up));
         check($sformatf("vec%0d pos", i), int'(pos), int'(tbl[i].pos));
         check($sformatf("vec%0d err", i), int'(err), int'(tbl[i].err));
      end

      // Twenty valid steps after the error: counting continues, err sticks.
      for (int i = 0; i < 20; i++) begin
         d  = ($urandom_range(0, 1) == 0) ? 1 : 3;
         pr = phinv[(m_ph + d) & 3];
         apply_model(pr[1], pr[0], 1'b1, 8, $sformatf("post_err%0d", i));
      end

      // Random walk with idle holds, occasional illegal jumps and en toggling.
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      d = 0;
         else if (r == 1) d = 2;
         else if (r < 6)  d = 1;
         else             d = 3;
         pr = phinv[(m_ph + d) & 3];
         apply_model(pr[1], pr[0], ($urandom_range(0, 3) != 0), $urandom_range(LAT + 2, 10),
                     $sformatf("rnd%0d", i));
      end

      // Asynchronous clear with a transition in flight.
      pr = phinv[(m_ph + 1) & 3];
      ch_a = pr[1]; ch_b = pr[0]; en = 1'b1;
      @(posedge clk);
      #2 clr = 1'b1;
      #1;
      check("async clr step", int'(step), 0);
      check("async clr up",   int'(up),   0);
      check("async clr pos",  int'(pos),  0);
      check("async clr err",  int'(err),  0);

      // Release clear with inputs at 11: priming must not count or flag.
      ch_a = 1'b1; ch_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      m_ph = 2; m_pos = 8'h00; m_up = 1'b0; m_err = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 12, 0, "prime11");
      check("prime11 pos", int'(pos), 0);
      check("prime11 err", int'(err), 0);
      apply_model(1'b1, 1'b0, 1'b1, 8, "after_prime");

`ifdef QDEC_FILTER_EN
      // Two-clock glitch on ch_a is rejected.
      ch_a = 1'b0;
      repeat (2) @(negedge clk);
      ch_a = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 10, 0, "glitch");
      check("glitch pos", int'(pos), int'(m_pos));
      check("glitch err", int'(err), 0);
      // A change held for four clocks is accepted.
      apply_model(1'b0, 1'b0, 1'b1, 8, "filt_step");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
